if_fetch_ctrl: RTL and testbench

//  Fetch-side consumer of the ID-stage hazard controls (PC_Write, IF_ID_Write, flush).

---
 rtl/if_fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: PC register, imem request handshake, one-entry skid buffer
// and IF/ID pipeline register, steered by the ID-stage hazard controls.
module if_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_Write,
  input  logic            IF_ID_Write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_pred_taken
);

  localparam int unsigned   ILEN     = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [ILEN-1:0]   skid_inst_q, skid_inst_d;
  logic              skid_pred_q, skid_pred_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [ILEN-1:0]   if_id_inst_q, if_id_inst_d;
  logic              if_id_pred_q, if_id_pred_d;

  // Candidate instruction offered to IF/ID this cycle (fresh response or skid).
  logic              dlv_en;
  logic [XLEN-1:0]   dlv_pc;
  logic [ILEN-1:0]   dlv_inst;
  logic              dlv_pred;

  // State register; reset abandons any outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= '0;
      skid_inst_q   <= NOP_INST;
      skid_pred_q   <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_pred_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      skid_pred_q   <= skid_pred_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pred_q  <= if_id_pred_d;
    end
  end

  // Next-state logic: flush outranks delivery, delivery outranks stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    skid_pred_d   = skid_pred_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pred_d  = if_id_pred_q;
    dlv_en        = 1'b0;
    dlv_pc        = pc_q;
    dlv_inst      = imem_rdata;
    dlv_pred      = pred_taken;

    if (flush && (state_q != ST_IDLE)) begin
      if_id_valid_d = 1'b0;
      pc_d          = redirect_pc;
      skid_valid_d  = 1'b0;
      state_d       = ST_REQ;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (imem_ready) begin
          // Request accepted; a simultaneous flush makes its response stale.
          drop_d  = flush;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // Response arriving in the flush cycle closes the request by itself.
          drop_d  = !imem_rvalid;
          state_d = imem_rvalid ? ST_REQ : ST_WAIT;
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            dlv_en = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (!flush && skid_valid_q) begin
          dlv_en   = 1'b1;
          dlv_pc   = skid_pc_q;
          dlv_inst = skid_inst_q;
          dlv_pred = skid_pred_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Hand the instruction to IF/ID, or park it in the skid while ID stalls.
    if (dlv_en) begin
      if (IF_ID_Write) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = dlv_pc;
        if_id_inst_d  = dlv_inst;
        if_id_pred_d  = dlv_pred;
        skid_valid_d  = 1'b0;
        state_d       = ST_REQ;
        if (PC_Write) begin
          pc_d = dlv_pred ? pred_target : pc_q + XLEN'(PC_STEP);
        end
      end else if (state_q == ST_WAIT) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = dlv_pc;
        skid_inst_d  = dlv_inst;
        skid_pred_d  = dlv_pred;
        state_d      = ST_HOLD;
      end
    end
  end

  assign imem_req         = (state_q == ST_REQ);
  assign imem_addr        = pc_q;
  assign if_id_valid      = if_id_valid_q;
  assign if_id_pc         = if_id_pc_q;
  assign if_id_inst       = if_id_inst_q;
  assign if_id_pred_taken = if_id_pred_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: imem responder model plus an IF/ID scoreboard.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_Write = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  exp_t sb[$];

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .flush(flush), .redirect_pc(redirect_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .if_id_pred_taken(if_id_pred_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Predictor model: taken only for one chosen PC.
  logic        pred_en = 1'b0;
  logic [31:0] pred_pc = '0;
  always_comb pred_taken = pred_en && (imem_addr == pred_pc);

  // Imem responder: one rvalid per accepted request, resp_delay cycles late.
  logic        acc_s = 1'b0;
  logic [31:0] acc_a = '0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          pcnt = 0;
  int          resp_delay = 0;

  always @(negedge clk) begin
    acc_s = imem_req && imem_ready;
    acc_a = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (acc_s) begin
      pend  = 1'b1;
      paddr = acc_a;
      pcnt  = resp_delay;
    end
    if (pend) begin
      if (pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(paddr);
        pend        = 1'b0;
      end else begin
        pcnt--;
      end
    end
  end

  // Scoreboard monitor: every new IF/ID content must match the queue head.
  exp_t last_obs = '0;
  logic last_val = 1'b0;
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{pc: if_id_pc, inst: if_id_inst, pred: if_id_pred_taken};
    if (!rst && if_id_valid && (!last_val || cur != last_obs)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL ifid_unexpected: got pc=%h inst=%h pred=%0b, expected no update",
                 if_id_pc, if_id_inst, if_id_pred_taken);
      end else begin
        e = sb.pop_front();
        if (cur !== e) begin
          miscompares++;
          $display("FAIL ifid_content: got pc=%h inst=%h pred=%0b, expected pc=%h inst=%h pred=%0b",
                   if_id_pc, if_id_inst, if_id_pred_taken, e.pc, e.inst, e.pred);
        end
      end
    end
    last_obs = cur;
    last_val = if_id_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    sb.push_back('{pc: pc, inst: inst_of(pc), pred: pred});
  endtask

  task automatic run_until_req(input logic [31:0] a, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (imem_req && imem_addr == a) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL req_timeout: no request to %h, last addr=%h req=%0b", a, imem_addr, imem_req);
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d expected instructions never reached IF/ID, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors += 6;
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %0b expected 0", imem_req); end
    if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", imem_addr); end
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b expected 0", if_id_valid); end
    if (if_id_pc !== 32'h0) begin miscompares++; $display("FAIL rst_ifid_pc: got %h expected 0", if_id_pc); end
    if (if_id_inst !== NOP) begin miscompares++; $display("FAIL rst_inst: got %h expected %h", if_id_inst, NOP); end
    if (if_id_pred_taken !== 1'b0) begin miscompares++; $display("FAIL rst_pred: got %0b expected 0", if_id_pred_taken); end
  endtask

  task automatic test_sequential();
    int n;
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    push(32'h8, 1'b0);
    push(32'hC, 1'b0);
    imem_ready = 1'b1;
    rst = 1'b0;
    run_until_req(32'h10, n);
    imem_ready = 1'b0;
    vectors++;
    if (n !== 9) begin miscompares++; $display("FAIL seq_cycles: got %0d expected 9", n); end
    wait_sb("seq");
  endtask

  task automatic test_stall();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    PC_Write = 1'b0;
    IF_ID_Write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors += 3;
      if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req: got %0b expected 0", imem_req); end
      if (if_id_pc !== 32'hC) begin miscompares++; $display("FAIL stall_ifid_pc: got %h expected 0000000c", if_id_pc); end
      if (if_id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %0b expected 1", if_id_valid); end
    end
    push(32'h10, 1'b0);
    PC_Write = 1'b1;
    IF_ID_Write = 1'b1;
    step();
    vectors += 2;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      miscompares++; $display("FAIL stall_next_req: got req=%0b addr=%h expected req=1 addr=00000014", imem_req, imem_addr);
    end
    if (if_id_inst !== inst_of(32'h10)) begin
      miscompares++; $display("FAIL stall_inst: got %h expected %h", if_id_inst, inst_of(32'h10));
    end
    wait_sb("stall");
  endtask

  task automatic test_flush_wait();
    int n;
    resp_delay = 2;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    flush = 1'b1;
    redirect_pc = 32'h100;
    step();
    flush = 1'b0;
    vectors += 2;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL fwait_valid: got %0b expected 0", if_id_valid); end
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL fwait_req: got %0b expected 0", imem_req); end
    push(32'h100, 1'b0);
    resp_delay = 0;
    imem_ready = 1'b1;
    run_until_req(32'h100, n);
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL fwait_redirect_cycles: got %0d expected 2", n); end
    run_until_req(32'h104, n);
    imem_ready = 1'b0;
    wait_sb("fwait");
  endtask

  task automatic test_flush_hold();
    int n;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    PC_Write = 1'b0;
    IF_ID_Write = 1'b0;
    step();
    step();
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL fhold_req: got %0b expected 0", imem_req); end
    flush = 1'b1;
    redirect_pc = 32'h200;
    step();
    flush = 1'b0;
    PC_Write = 1'b1;
    IF_ID_Write = 1'b1;
    vectors += 2;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL fhold_valid: got %0b expected 0", if_id_valid); end
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      miscompares++; $display("FAIL fhold_target: got req=%0b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
    end
    push(32'h200, 1'b0);
    imem_ready = 1'b1;
    run_until_req(32'h204, n);
    imem_ready = 1'b0;
    wait_sb("fhold");
  endtask

  task automatic test_predict();
    int n;
    pred_en = 1'b1;
    pred_pc = 32'h204;
    pred_target = 32'h40;
    push(32'h204, 1'b1);
    push(32'h40, 1'b0);
    imem_ready = 1'b1;
    run_until_req(32'h40, n);
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL pred_cycles: got %0d expected 2", n); end
    run_until_req(32'h44, n);
    imem_ready = 1'b0;
    pred_en = 1'b0;
    wait_sb("pred");
  endtask

  task automatic test_reset_wait_and_wrap();
    int n;
    resp_delay = 1;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    resp_delay = 0;
    step();
    for (int c = 0; c < 2; c++) begin
      vectors += 3;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        miscompares++; $display("FAIL rwait_req: got req=%0b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
      end
      if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL rwait_valid: got %0b expected 0", if_id_valid); end
      if (if_id_inst !== NOP) begin miscompares++; $display("FAIL rwait_inst: got %h expected %h", if_id_inst, NOP); end
      step();
    end
    flush = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    vectors++;
    if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_retarget: got %h expected fffffffc", imem_addr); end
    push(32'hFFFF_FFFC, 1'b0);
    imem_ready = 1'b1;
    run_until_req(32'h0, n);
    imem_ready = 1'b0;
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL wrap_cycles: got %0d expected 2", n); end
    wait_sb("wrap");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_hold();
    test_predict();
    test_reset_wait_and_wrap();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
